net_frame_arbiter: RTL and testbench
====================================

// Module: net_frame_arbiter
// PURPOSE
//  Shares one streaming network instance (e.g. net_4_8_12_16_16_1_20) between two requesters at
//  frame granularity. Grants a whole input frame of IN_LEN words to one source, round-robin.
//  Records the source of each granted frame in a tag FIFO, then routes each OUT_LEN-word result
//  frame back to its source in issue order. Sits between two producers/consumers and the net ports.
// PARAMETERS
//  W          16  data word width (matches network data width)
//  IN_LEN      4  words per input frame (network input vector length)
//  OUT_LEN    16  words per output frame (network output vector length)
//  TAG_DEPTH   4  max frames in flight (granted, result not fully returned); power of 2, >=2
// PORTS
//  clk              in   1        clock, all state on rising edge
//  reset            in   1        asynchronous, active-high reset
//  s0_valid/s1_valid in  1        requester input word valid
//  s0_ready/s1_ready out 1        requester input word accepted
//  s0_data/s1_data  in   W signed requester input word
//  net_in_valid     out  1        to network input_valid
//  net_in_ready     in   1        from network input_ready
//  net_in_data      out  W signed to network input_data
//  net_out_valid    in   1        from network output_valid
//  net_out_ready    out  1        to network output_ready
//  net_out_data     in   W signed from network output_data
//  m0_valid/m1_valid out 1        result word valid to requester 0/1
//  m0_ready/m1_ready in  1        requester 0/1 result ready
//  m0_data/m1_data  out  W signed result word (both driven with net_out_data)
//  frames_in_flight out  $clog2(TAG_DEPTH+1)  tag FIFO occupancy
// BEHAVIOUR
//  Reset: state IDLE, rr pointer=0 (requester 0 preferred), counters 0, tag FIFO empty.
//   All outputs 0 while reset is asserted and in IDLE with empty FIFO.
//  Input FSM states: IDLE, GRANT0, GRANT1.
//   IDLE: if FIFO not full and any sx_valid: pick single requester; if both, pick !rr.
//     rr starts at 1 effectively so requester 0 is first after reset.
//     Next state GRANTx. Push tag x into FIFO on this same edge. No data moves in IDLE.
//   GRANTx: net_in_valid=sx_valid, sx_ready=net_in_ready, net_in_data=sx_data.
//     Other requester's ready=0. in_cnt increments per net_in handshake.
//     On IN_LEN-th handshake: in_cnt->0, rr<=x, state->IDLE. One bubble cycle between frames.
//   sx_valid dropping mid-frame: grant held indefinitely. Frames are never split or interleaved.
//  Output router: combinational on FIFO head tag h.
//   FIFO empty: net_out_ready=0, m0_valid=m1_valid=0.
//   Non-empty: mh_valid=net_out_valid, net_out_ready=mh_ready, other m valid=0.
//   out_cnt increments per net_out handshake. On OUT_LEN-th: out_cnt->0, pop FIFO.
//   Strictly in-order: a stalled mh_ready blocks all results (no bypass).
//  FIFO: push (IDLE grant) and pop (last output word) in same cycle allowed.
//   Occupancy unchanged in that case. Push only when count<TAG_DEPTH; pop only when non-empty.
//   frames_in_flight is registered occupancy, range 0..TAG_DEPTH.
//  Reset mid-operation: all state cleared asynchronously; partial frames are discarded.
//   The network must be reset on the same reset net.
//  No arithmetic on data; words pass through unmodified with zero added latency.
// TESTING
//  1 s0 only sends 1,2,3,4; net model returns 16 words 100..115 -> all 16 on m0 in order.
//    m1_valid stays 0; frames_in_flight goes 0->1->0.
//  2 s0,s1 continuously valid -> grants 0,1,0,1 with one IDLE cycle between frames.
//    Results route m0,m1,m0,m1; s1_ready=0 throughout GRANT0.
//  3 head tag=1, m1_ready=0, m0_ready=1 -> net_out_ready=0, no m0 transfer.
//    m1_ready=1 -> resumes.
//  4 hold net_out_ready path stalled (m0_ready=0), s0 streams -> 4 grants, frames_in_flight=4.
//    5th frame s0_ready stays 0; after 16 results drain, 5th grant occurs.
//  5 s0_valid toggles 1,0,0,1,1,0,1 during GRANT0 -> exactly 4 words forwarded.
//    No s1 grant before the frame completes.
//  6 reset pulse after 2 words of a frame -> outputs 0, frames_in_flight=0.
//    After release with both valid, s0 granted first.

Source files
------------

// File: rtl/net_frame_arbiter.sv
// -----------------------------------------------------------------------------
// net_frame_arbiter
//
// Shares one streaming network between two requesters at frame granularity.
// A whole IN_LEN-word input frame is granted to one requester (round-robin);
// the granted source is pushed into a small tag FIFO, and each OUT_LEN-word
// result frame coming back from the network is routed to the source at the
// head of that FIFO, strictly in issue order.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   s0_/s1_valid,ready,data    requester input streams (to the network)
//   net_in_valid,ready,data    network input port
//   net_out_valid,ready,data   network output port
//   m0_/m1_valid,ready,data    result streams back to the requesters
//   frames_in_flight           registered tag FIFO occupancy (0..TAG_DEPTH)
//
// Data passes through combinationally: no added latency, no modification.
// -----------------------------------------------------------------------------
module net_frame_arbiter #(
  parameter int W         = 16,
  parameter int IN_LEN    = 4,
  parameter int OUT_LEN   = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,

  input  logic                           s0_valid,
  output logic                           s0_ready,
  input  logic signed [W-1:0]            s0_data,
  input  logic                           s1_valid,
  output logic                           s1_ready,
  input  logic signed [W-1:0]            s1_data,

  output logic                           net_in_valid,
  input  logic                           net_in_ready,
  output logic signed [W-1:0]            net_in_data,
  input  logic                           net_out_valid,
  output logic                           net_out_ready,
  input  logic signed [W-1:0]            net_out_data,

  output logic                           m0_valid,
  input  logic                           m0_ready,
  output logic signed [W-1:0]            m0_data,
  output logic                           m1_valid,
  input  logic                           m1_ready,
  output logic signed [W-1:0]            m1_data,

  output logic [$clog2(TAG_DEPTH+1)-1:0] frames_in_flight
);

  localparam int IN_CW  = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
  localparam int OUT_CW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int PW     = $clog2(TAG_DEPTH);
  localparam int CNT_W  = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  // Input side state
  state_e             state_q,   state_d;
  logic               prefer_q,  prefer_d;   // requester favoured on a tie
  logic [IN_CW-1:0]   in_cnt_q,  in_cnt_d;

  // Output side / tag FIFO state
  logic [OUT_CW-1:0]  out_cnt_q, out_cnt_d;
  logic [PW-1:0]      wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic               tag_mem [TAG_DEPTH];

  logic               push, pop, push_tag;
  logic               fifo_full, fifo_empty, head_tag;

  assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_tag   = tag_mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Input arbitration FSM: IDLE picks a requester and reserves a tag slot,
  // GRANTx forwards exactly IN_LEN words from that requester only.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    prefer_d     = prefer_q;
    in_cnt_d     = in_cnt_q;
    push         = 1'b0;
    push_tag     = 1'b0;
    net_in_valid = 1'b0;
    net_in_data  = '0;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_full && (s0_valid || s1_valid)) begin
          push     = 1'b1;
          push_tag = (s0_valid && s1_valid) ? prefer_q : s1_valid;
          state_d  = push_tag ? GRANT1 : GRANT0;
        end
      end

      GRANT0: begin
        net_in_valid = s0_valid;
        net_in_data  = s0_data;
        s0_ready     = net_in_ready;
        if (s0_valid && net_in_ready) begin
          if (in_cnt_q == IN_CW'(IN_LEN - 1)) begin
            in_cnt_d = '0;
            prefer_d = 1'b1;
            state_d  = IDLE;
          end else begin
            in_cnt_d = in_cnt_q + IN_CW'(1);
          end
        end
      end

      GRANT1: begin
        net_in_valid = s1_valid;
        net_in_data  = s1_data;
        s1_ready     = net_in_ready;
        if (s1_valid && net_in_ready) begin
          if (in_cnt_q == IN_CW'(IN_LEN - 1)) begin
            in_cnt_d = '0;
            prefer_d = 1'b0;
            state_d  = IDLE;
          end else begin
            in_cnt_d = in_cnt_q + IN_CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output router: the head tag selects which requester sees the network
  // output. A stalled head consumer blocks everything behind it.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_cnt_d     = out_cnt_q;
    pop           = 1'b0;
    net_out_ready = 1'b0;
    m0_valid      = 1'b0;
    m1_valid      = 1'b0;

    if (!fifo_empty) begin
      if (head_tag) begin
        m1_valid      = net_out_valid;
        net_out_ready = m1_ready;
      end else begin
        m0_valid      = net_out_valid;
        net_out_ready = m0_ready;
      end
      if (net_out_valid && net_out_ready) begin
        if (out_cnt_q == OUT_CW'(OUT_LEN - 1)) begin
          out_cnt_d = '0;
          pop       = 1'b1;
        end else begin
          out_cnt_d = out_cnt_q + OUT_CW'(1);
        end
      end
    end
  end

  assign m0_data = net_out_data;
  assign m1_data = net_out_data;

  // Tag FIFO bookkeeping; push and pop in the same cycle leave occupancy as is.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign frames_in_flight = count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prefer_q  <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      prefer_q  <= prefer_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: the tag storage is deliberately not reset; an entry is only read
  // while count_q says it holds a valid tag, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= push_tag;
  end

endmodule

// File: tb/tb_net_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_net_frame_arbiter
//
// Directed bench for net_frame_arbiter. A small network model accepts 4-word
// frames and returns 16 words per frame: word i = first_input_word*100 + i.
// Inputs are driven on the falling edge; handshakes are logged on the rising
// edge; outputs are sampled just after the falling edge.
// -----------------------------------------------------------------------------
module tb_net_frame_arbiter;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                s0_valid, s0_ready, s1_valid, s1_ready;
  logic signed [W-1:0] s0_data, s1_data;
  logic                net_in_valid, net_in_ready;
  logic signed [W-1:0] net_in_data;
  logic                net_out_valid, net_out_ready;
  logic signed [W-1:0] net_out_data;
  logic                m0_valid, m0_ready, m1_valid, m1_ready;
  logic signed [W-1:0] m0_data, m1_data;
  logic [2:0]          frames_in_flight;

  net_frame_arbiter #(.W(W), .IN_LEN(4), .OUT_LEN(16), .TAG_DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .s0_valid         (s0_valid),
    .s0_ready         (s0_ready),
    .s0_data          (s0_data),
    .s1_valid         (s1_valid),
    .s1_ready         (s1_ready),
    .s1_data          (s1_data),
    .net_in_valid     (net_in_valid),
    .net_in_ready     (net_in_ready),
    .net_in_data      (net_in_data),
    .net_out_valid    (net_out_valid),
    .net_out_ready    (net_out_ready),
    .net_out_data     (net_out_data),
    .m0_valid         (m0_valid),
    .m0_ready         (m0_ready),
    .m0_data          (m0_data),
    .m1_valid         (m1_valid),
    .m1_ready         (m1_ready),
    .m1_data          (m1_data),
    .frames_in_flight (frames_in_flight)
  );

  // ---------------------------------------------------------------- net model
  logic                net_out_en;
  logic signed [W-1:0] res_mem [256];
  logic [7:0]          res_wr, res_rd;
  logic signed [W-1:0] mdl_first;
  int                  mdl_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      res_wr  <= '0;
      res_rd  <= '0;
      mdl_cnt <= 0;
    end else begin
      if (net_in_valid && net_in_ready) begin
        if (mdl_cnt == 0) mdl_first <= net_in_data;
        if (mdl_cnt == 3) begin
          for (int i = 0; i < 16; i++)
            res_mem[res_wr + 8'(i)] <= W'(int'(mdl_first) * 100 + i);
          res_wr  <= res_wr + 8'd16;
          mdl_cnt <= 0;
        end else begin
          mdl_cnt <= mdl_cnt + 1;
        end
      end
      if (net_out_valid && net_out_ready) res_rd <= res_rd + 8'd1;
    end
  end

  assign net_out_valid = net_out_en && (res_rd != res_wr);
  assign net_out_data  = res_mem[res_rd];

  // ---------------------------------------------------------------- monitor
  int cyc;
  int m0_log[$], m1_log[$], grant_log[$], grant_cyc[$], net_in_log[$];
  int in_pos, both_ready, both_mvalid, ffi_max, m1_sz_at_m0, m0_sz_at_g5;
  int s0_cnt, s1_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      in_pos = 0;
    end else begin
      cyc++;
      if (s0_ready && s1_ready) both_ready++;
      if (m0_valid && m1_valid) both_mvalid++;
      if (m0_valid && m0_ready) begin
        if (m0_log.size() == 0) m1_sz_at_m0 = m1_log.size();
        m0_log.push_back(int'(m0_data));
      end
      if (m1_valid && m1_ready) m1_log.push_back(int'(m1_data));
      if (net_in_valid && net_in_ready) begin
        if (in_pos == 0) begin
          grant_log.push_back((s0_valid && s0_ready) ? 0 : 1);
          grant_cyc.push_back(cyc);
          if (grant_log.size() == 5) m0_sz_at_g5 = m0_log.size();
        end
        net_in_log.push_back(int'(net_in_data));
        in_pos = (in_pos + 1) % 4;
      end
      if (s0_valid && s0_ready) s0_cnt++;
      if (s1_valid && s1_ready) s1_cnt++;
      if (int'(frames_in_flight) > ffi_max) ffi_max = int'(frames_in_flight);
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic s0_en, s1_en, s0_hold;
  int   s0_base, s1_base, s0_lim, s1_lim;
  int   n_checks, n_pass;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_logs();
    m0_log.delete(); m1_log.delete(); grant_log.delete();
    grant_cyc.delete(); net_in_log.delete();
    both_ready = 0; both_mvalid = 0; ffi_max = 0;
    m1_sz_at_m0 = -1; m0_sz_at_g5 = -1; s0_cnt = 0; s1_cnt = 0;
  endtask

  task automatic step();
    @(negedge clk);
    s0_valid = s0_en && (s0_cnt < s0_lim) && !s0_hold;
    s0_data  = W'(s0_base + s0_cnt);
    s1_valid = s1_en && (s1_cnt < s1_lim);
    s1_data  = W'(s1_base + s1_cnt);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s0_en = 1'b0; s1_en = 1'b0; s0_hold = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
    m0_ready = 1'b1; m1_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    clear_logs();
    s0_en = 0; s1_en = 0; s0_hold = 0;
    s0_base = 0; s1_base = 0; s0_lim = 0; s1_lim = 0;
    net_in_ready = 1'b1; net_out_en = 1'b1;
    m0_ready = 1'b1; m1_ready = 1'b1;
    s0_data = '0; s1_data = '0;
    reset = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1;   // requests during reset must be ignored

    // ---- reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_net_in_valid",  net_in_valid,     0);
    check("rst_s0_ready",      s0_ready,         0);
    check("rst_s1_ready",      s1_ready,         0);
    check("rst_ffi",           frames_in_flight, 0);
    check("rst_net_out_ready", net_out_ready,    0);
    check("rst_m0_valid",      m0_valid,         0);
    check("rst_m1_valid",      m1_valid,         0);
    s0_valid = 1'b0; s1_valid = 1'b0;
    reset = 1'b0;

    // ---- test 1: single s0 frame 1..4 -> 100..115 on m0
    s0_base = 1; s0_lim = 4; s0_en = 1;
    step();
    step();
    check("t1_ffi_after_grant", frames_in_flight, 1);
    check("t1_s0_ready",        s0_ready,         1);
    for (int k = 0; k < 100 && !(m0_log.size() == 16 && frames_in_flight == 0); k++) step();
    check("t1_m0_count", m0_log.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("t1_m0_word%0d", i), m0_log[i], 100 + i);
    check("t1_m1_count", m1_log.size(), 0);
    check("t1_ffi_end",  frames_in_flight, 0);
    check("t1_ffi_max",  ffi_max, 1);
    check("t1_net_in_last", net_in_log[3], 4);

    // ---- test 2: both continuously valid -> 0,1,0,1 with one bubble
    do_reset();
    s0_base = 1;  s0_lim = 8; s0_en = 1;
    s1_base = 50; s1_lim = 8; s1_en = 1;
    for (int k = 0; k < 300 && !(m0_log.size() == 32 && m1_log.size() == 32); k++) step();
    check("t2_grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_grant%0d", i), grant_log[i], i % 2);
    check("t2_gap01", grant_cyc[1] - grant_cyc[0], 5);
    check("t2_gap12", grant_cyc[2] - grant_cyc[1], 5);
    check("t2_both_ready", both_ready, 0);
    check("t2_both_mvalid", both_mvalid, 0);
    check("t2_m0_f0", m0_log[0],  100);
    check("t2_m0_f1", m0_log[16], 500);
    check("t2_m1_f0", m1_log[0],  5000);
    check("t2_m1_f1", m1_log[16], 5400);
    check("t2_m1_last", m1_log[31], 5415);

    // ---- test 3: head tag 1 stalled blocks m0 results
    do_reset();
    m1_ready = 0;
    s1_base = 7; s1_lim = 4; s1_en = 1;
    for (int k = 0; k < 20 && s1_cnt < 4; k++) step();
    s0_base = 2; s0_lim = 4; s0_en = 1;
    repeat (20) step();
    check("t3_s0_accepted",    s0_cnt, 4);
    check("t3_ffi",            frames_in_flight, 2);
    check("t3_net_out_ready",  net_out_ready, 0);
    check("t3_m1_valid",       m1_valid, 1);
    check("t3_m0_valid",       m0_valid, 0);
    check("t3_m0_none",        m0_log.size(), 0);
    check("t3_m1_none",        m1_log.size(), 0);
    m1_ready = 1;
    for (int k = 0; k < 100 && m0_log.size() < 16; k++) step();
    check("t3_m1_first", m1_log[0],  700);
    check("t3_m1_last",  m1_log[15], 715);
    check("t3_m0_first", m0_log[0],  200);
    check("t3_in_order", m1_sz_at_m0, 16);

    // ---- test 4: stalled outputs fill the tag FIFO
    do_reset();
    m0_ready = 0;
    s0_base = 1; s0_lim = 20; s0_en = 1;
    repeat (40) step();
    check("t4_ffi_full",       frames_in_flight, 4);
    check("t4_s0_words",       s0_cnt, 16);
    check("t4_s0_valid",       s0_valid, 1);
    check("t4_s0_ready_full",  s0_ready, 0);
    check("t4_grants",         grant_log.size(), 4);
    check("t4_net_out_ready",  net_out_ready, 0);
    m0_ready = 1;
    for (int k = 0; k < 100 && s0_cnt < 20; k++) step();
    check("t4_s0_all",         s0_cnt, 20);
    check("t4_drain_first",    int'(m0_sz_at_g5 >= 16), 1);
    for (int k = 0; k < 200 && !(m0_log.size() == 80 && frames_in_flight == 0); k++) step();
    check("t4_m0_count",       m0_log.size(), 80);
    check("t4_m0_f4",          m0_log[64], 1700);
    check("t4_ffi_end",        frames_in_flight, 0);
    check("t4_ffi_max",        ffi_max, 4);

    // ---- test 5: gappy s0_valid during GRANT0
    do_reset();
    s0_base = 10; s0_lim = 100; s0_en = 1;
    s1_base = 60; s1_lim = 4;   s1_en = 1;
    step();
    for (int i = 0; i < 7; i++) begin
      s0_hold = !pat[i];
      step();
      if (i == 1) check("t5_s1_ready_hold", s1_ready, 0);
    end
    s0_hold = 0; s0_en = 0;
    step();
    check("t5_s0_words",   s0_cnt, 4);
    check("t5_net_in_n",   net_in_log.size(), 4);
    check("t5_net_in_0",   net_in_log[0], 10);
    check("t5_net_in_3",   net_in_log[3], 13);
    check("t5_s1_none",    s1_cnt, 0);
    check("t5_grants_1",   grant_log.size(), 1);
    repeat (10) step();
    check("t5_grants_2",   grant_log.size(), 2);
    check("t5_grant1_src", grant_log[1], 1);
    check("t5_s1_words",   s1_cnt, 4);

    // ---- test 6: reset mid-frame
    do_reset();
    s0_base = 1; s0_lim = 6; s0_en = 1;
    for (int k = 0; k < 30 && s0_cnt < 6; k++) step();
    check("t6_pre_words", s0_cnt, 6);
    reset = 1'b1;
    #1;
    check("t6_rst_net_in_valid",  net_in_valid, 0);
    check("t6_rst_s0_ready",      s0_ready, 0);
    check("t6_rst_ffi",           frames_in_flight, 0);
    check("t6_rst_m0_valid",      m0_valid, 0);
    check("t6_rst_net_out_ready", net_out_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    s0_base = 30; s0_lim = 4; s0_en = 1;
    s1_base = 40; s1_lim = 4; s1_en = 1;
    for (int k = 0; k < 20 && grant_log.size() < 1; k++) step();
    check("t6_first_grant", grant_log[0], 0);
    for (int k = 0; k < 20 && grant_log.size() < 2; k++) step();
    check("t6_second_grant", grant_log[1], 1);
    check("t6_first_word", net_in_log[0], 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
